// File: rtl/frame_collector.sv
// frame_collector: stores one IMG_W x IMG_H frame of pixel bytes from a UART
// receiver into an on-chip buffer. Pixels are written in row-major order and
// the buffer can be read at any time through a one-cycle-latency read port.
// A finished frame is held until the consumer acknowledges it. Bytes that
// arrive while a frame is held are dropped and flagged as an overrun.
// Optional feature: define FRAME_CHECKSUM_EN to add o_checksum, the 16-bit
// running sum of the bytes written into the current frame.
module frame_collector #(
    parameter int D_BITS = 8,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    localparam int NPIX  = IMG_W * IMG_H,
    localparam int AW    = (NPIX  > 1) ? $clog2(NPIX)  : 1,
    localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [D_BITS-1:0] i_data,
    input  logic              i_rx_done,
    input  logic              i_frame_ack,
    input  logic              i_rd_en,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [D_BITS-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic [CW-1:0]     o_col,
    output logic [RW-1:0]     o_row,
    output logic              o_frame_done,
`ifdef FRAME_CHECKSUM_EN
    output logic [15:0]       o_checksum,
`endif
    output logic              o_overrun
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     col_q;
    logic [RW-1:0]     row_q;
    logic [CW-1:0]     col_d;
    logic [RW-1:0]     row_d;
    logic              frame_done_q;
    logic              overrun_q;
    logic [D_BITS-1:0] rd_data_q;
    logic              rd_valid_q;
    logic [D_BITS-1:0] mem_q [0:NPIX-1];

    logic              col_last_s;
    logic              row_last_s;
    logic              frame_last_s;
    logic              wr_en_s;
    logic [AW-1:0]     wr_addr_s;
    logic              rd_in_range_s;

`ifdef FRAME_CHECKSUM_EN
    logic [15:0]       checksum_q;
`endif

    assign col_last_s    = (col_q == CW'(IMG_W - 1));
    assign row_last_s    = (row_q == RW'(IMG_H - 1));
    assign frame_last_s  = col_last_s && row_last_s;
    // Writes are gated by reset so an edge seen while reset is held never
    // touches the buffer.
    assign wr_en_s       = i_rst_n && i_rx_done && (state_q != S_DONE);
    assign wr_addr_s     = AW'(row_q) * AW'(IMG_W) + AW'(col_q);
    assign rd_in_range_s = (32'(i_rd_addr) < 32'(NPIX));

    // Next write position: advance the column, wrapping into the next row and
    // back to the origin after the last pixel.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (col_last_s) begin
            col_d = {CW{1'b0}};
            if (row_last_s) begin
                row_d = {RW{1'b0}};
            end else begin
                row_d = row_q + RW'(1);
            end
        end else begin
            col_d = col_q + CW'(1);
        end
    end

    // Frame FSM with registered position, frame-done, overrun and checksum.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            col_q        <= {CW{1'b0}};
            row_q        <= {RW{1'b0}};
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            checksum_q   <= 16'h0000;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_rx_done) begin
                        col_q        <= col_d;
                        row_q        <= row_d;
                        state_q      <= frame_last_s ? S_DONE : S_COLLECT;
                        frame_done_q <= frame_last_s;
`ifdef FRAME_CHECKSUM_EN
                        // First byte of a new frame restarts the sum.
                        checksum_q   <= 16'(i_data);
`endif
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_COLLECT: begin
                    if (i_rx_done) begin
                        col_q <= col_d;
                        row_q <= row_d;
`ifdef FRAME_CHECKSUM_EN
                        checksum_q <= checksum_q + 16'(i_data);
`endif
                        if (frame_last_s) begin
                            state_q      <= S_DONE;
                            frame_done_q <= 1'b1;
                        end else begin
                            state_q <= S_COLLECT;
                        end
                    end else begin
                        state_q <= S_COLLECT;
                    end
                end
                S_DONE: begin
                    if (i_rx_done) begin
                        overrun_q <= 1'b1;
                    end else begin
                        overrun_q <= overrun_q;
                    end
                    if (i_frame_ack) begin
                        state_q      <= S_IDLE;
                        frame_done_q <= 1'b0;
                    end else begin
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    frame_done_q <= 1'b0;
                end
            endcase
        end
    end

    // Frame buffer write port; contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (wr_en_s) begin
            mem_q[wr_addr_s] <= i_data;
        end
    end

    // Read port: one-cycle latency, returns pre-write data on a same-address
    // collision and zero for addresses beyond the frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= {D_BITS{1'b0}};
        end else begin
            rd_valid_q <= i_rd_en;
            if (i_rd_en) begin
                if (rd_in_range_s) begin
                    rd_data_q <= mem_q[i_rd_addr];
                end else begin
                    rd_data_q <= {D_BITS{1'b0}};
                end
            end else begin
                rd_data_q <= rd_data_q;
            end
        end
    end

    assign o_rd_data    = rd_data_q;
    assign o_rd_valid   = rd_valid_q;
    assign o_col        = col_q;
    assign o_row        = row_q;
    assign o_frame_done = frame_done_q;
    assign o_overrun    = overrun_q;
`ifdef FRAME_CHECKSUM_EN
    assign o_checksum   = checksum_q;
`endif

endmodule
